// File: rtl/serial_sub_if.sv
// rtl/serial_sub_if.sv - operand/result bundle for the serial subtractor
interface serial_sub_if #(
  parameter int W = 16
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bout;
  logic         ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, d, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, d, bout, ovf
  );
endinterface

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - digit-serial subtractor D = A - B - Bin with registered borrow chain
module serial_sub #(
  parameter int W  = 16,
  parameter int DW = 4
) (
  input  logic       clk,
  input  logic       rst,
  serial_sub_if.slave bus
);
  localparam int NDIG = W / DW;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic [W-1:0]  acc;
  logic          borrow;
  logic          a_msb;
  logic          b_msb;

  logic [DW:0]   diff;
  logic [W-1:0]  d_full;
  logic          ovf_next;

  // Operands shift right so the digit under work is always in the low DW bits.
  always_comb begin
    diff     = {1'b0, op_a[DW-1:0]} - {1'b0, op_b[DW-1:0]} - {{DW{1'b0}}, borrow};
    d_full   = acc;
    d_full[W-1 -: DW] = diff[DW-1:0];
    ovf_next = (a_msb != b_msb) && (d_full[W-1] != a_msb);
  end

  assign bus.busy = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      op_a     <= '0;
      op_b     <= '0;
      acc      <= '0;
      borrow   <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      bus.done <= 1'b0;
      bus.d    <= '0;
      bus.bout <= 1'b0;
      bus.ovf  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= RUN;
            cnt    <= '0;
            op_a   <= bus.a;
            op_b   <= bus.b;
            borrow <= bus.bin;
            a_msb  <= bus.a[W-1];
            b_msb  <= bus.b[W-1];
            acc    <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < NDIG; i++) begin
            if (cnt == CW'(i)) acc[i*DW +: DW] <= diff[DW-1:0];
          end
          op_a   <= op_a >> DW;
          op_b   <= op_b >> DW;
          borrow <= diff[DW];
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            state    <= IDLE;
            bus.d    <= d_full;
            bus.bout <= diff[DW];
            bus.ovf  <= ovf_next;
            bus.done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
